// File: rtl/repvgg_col_engine.sv
`default_nettype none
// ============================================================================
//  Module      : repvgg_col_engine
//  Description : Column-streaming RepVGG block engine. Computes one output
//                channel (3x3 + optional 1x1 + optional identity) over an
//                HIT x WID map, accumulating CIN input channels in an internal
//                column buffer, then drains ReLU'd columns.
//  Revision    : 1.0 - initial release
// ============================================================================
module repvgg_col_engine #(
    parameter int HIT = 56,
    parameter int WID = 56,
    parameter int CIN = 64,
    parameter int DW  = 32,
    parameter int FW  = 8,
    parameter int SAT = 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic [1:0]                             mode,
    input  logic [((CIN > 1) ? $clog2(CIN) : 1)-1:0] oc_idx,
    output logic                                   busy,
    input  logic [10*DW-1:0]                       wht_i,
    input  logic                                   wht_valid,
    output logic                                   wht_ready,
    input  logic [HIT*DW-1:0]                      fmap_i,
    input  logic                                   fmap_valid,
    output logic                                   fmap_ready,
    output logic [HIT*DW-1:0]                      data_o,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   done
);

    localparam int CW = (CIN > 1) ? $clog2(CIN) : 1;
    localparam int AW = (WID > 1) ? $clog2(WID) : 1;

    typedef logic signed [DW-1:0] word_t;
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_STREAM = 3'd2,
        S_FLUSH  = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    localparam word_t MAXV = {1'b0, {(DW-1){1'b1}}};
    localparam word_t MINV = {1'b1, {(DW-1){1'b0}}};

    // Add with either saturation or two's-complement wrap.
    function automatic word_t sat_add(input word_t a, input word_t b);
        logic [DW:0] s;
        s = {a[DW-1], a} + {b[DW-1], b};
        if (SAT != 0 && (s[DW] != s[DW-1]))
            return s[DW] ? MINV : MAXV;
        return s[DW-1:0];
    endfunction

    // Fixed-point multiply: full-width product, arithmetic rescale, then clip or wrap.
    function automatic word_t mul_fx(input word_t a, input word_t b);
        logic signed [2*DW-1:0] p;
        p = $signed((2*DW)'(a)) * $signed((2*DW)'(b));
        p = p >>> FW;
        if (SAT != 0 && !((&p[2*DW-1:DW-1]) || (~|p[2*DW-1:DW-1])))
            return p[2*DW-1] ? MINV : MAXV;
        return p[DW-1:0];
    endfunction

    function automatic word_t relu(input word_t a);
        return a[DW-1] ? '0 : a;
    endfunction

    state_t          state_q;
    logic            busy_q, out_valid_q, done_q;
    logic [1:0]      mode_q;
    logic [CW-1:0]   oc_q, ch_q;
    logic [AW-1:0]   col_q, dr_q;
    word_t           w_q    [10];
    word_t           prev_q [HIT];
    word_t           cur_q  [HIT];
    word_t           data_q [HIT];
    word_t           acc_mem [WID][HIT];

    word_t           pad     [3][HIT+2];
    word_t           acc_new [HIT];
    logic            wr_en;
    logic [AW-1:0]   wr_x, dr_nx;

    assign busy       = busy_q;
    assign out_valid  = out_valid_q;
    assign done       = done_q;
    assign wht_ready  = (state_q == S_LOAD_W);
    assign fmap_ready = (state_q == S_STREAM);

    generate
        for (genvar gy = 0; gy < HIT; gy++) begin : g_out
            assign data_o[gy*DW +: DW] = data_q[gy];
        end
    endgenerate

    // The column just completed is x = col_q-1 while streaming, WID-1 in FLUSH.
    assign wr_en = rst_n && (((state_q == S_STREAM) && fmap_valid && (col_q != '0)) ||
                             (state_q == S_FLUSH));
    assign wr_x  = (state_q == S_FLUSH) ? AW'(WID-1) : (col_q - 1'b1);
    assign dr_nx = (dr_q == AW'(WID-1)) ? '0 : (dr_q + 1'b1);

    // Zero-padded window columns and the new accumulator value for column wr_x.
    always_comb begin
        word_t s;
        s = '0;
        for (int kc = 0; kc < 3; kc++) begin
            pad[kc][0]     = '0;
            pad[kc][HIT+1] = '0;
        end
        for (int y = 0; y < HIT; y++) begin
            pad[0][y+1] = prev_q[y];
            pad[1][y+1] = cur_q[y];
            pad[2][y+1] = (state_q == S_STREAM) ? word_t'(fmap_i[y*DW +: DW]) : '0;
        end
        for (int y = 0; y < HIT; y++) begin
            s = '0;
            for (int kc = 0; kc < 3; kc++) begin
                for (int kr = 0; kr < 3; kr++) begin
                    s = sat_add(s, mul_fx(w_q[3*kc+kr], pad[kc][y+kr]));
                end
            end
            // w_q[9] is already zero in the fused modes, so the 1x1 term is always safe to add.
            s = sat_add(s, mul_fx(w_q[9], cur_q[y]));
            if ((mode_q == 2'd0) && (ch_q == oc_q))
                s = sat_add(s, cur_q[y]);
            acc_new[y] = (ch_q == '0) ? s : sat_add(acc_mem[wr_x][y], s);
        end
    end

    // Column buffer: deliberately without reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int y = 0; y < HIT; y++)
                acc_mem[wr_x][y] <= acc_new[y];
        end
    end

    // Job sequencer: weight load, column streaming, flush, and drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            mode_q      <= 2'd0;
            oc_q        <= '0;
            ch_q        <= '0;
            col_q       <= '0;
            dr_q        <= '0;
            for (int k = 0; k < 10; k++) w_q[k] <= '0;
            for (int y = 0; y < HIT; y++) begin
                prev_q[y] <= '0;
                cur_q[y]  <= '0;
                data_q[y] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q  <= (mode == 2'd3) ? 2'd1 : mode;
                        oc_q    <= oc_idx;
                        ch_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD_W;
                    end
                end
                S_LOAD_W: begin
                    if (wht_valid) begin
                        for (int k = 0; k < 10; k++)
                            w_q[k] <= wht_i[k*DW +: DW];
                        if (mode_q == 2'd1)
                            w_q[9] <= '0;
                        col_q   <= '0;
                        state_q <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (fmap_valid) begin
                        for (int y = 0; y < HIT; y++) begin
                            prev_q[y] <= (col_q == '0) ? '0 : cur_q[y];
                            cur_q[y]  <= fmap_i[y*DW +: DW];
                        end
                        col_q <= col_q + 1'b1;
                        if (col_q == AW'(WID-1))
                            state_q <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (ch_q == CW'(CIN-1)) begin
                        // With a single column the buffer is written at this edge; forward it.
                        for (int y = 0; y < HIT; y++)
                            data_q[y] <= relu((WID == 1) ? acc_new[y] : acc_mem[0][y]);
                        out_valid_q <= 1'b1;
                        dr_q        <= '0;
                        state_q     <= S_DRAIN;
                    end else begin
                        ch_q    <= ch_q + 1'b1;
                        state_q <= S_LOAD_W;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (dr_q == AW'(WID-1)) begin
                            out_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= S_IDLE;
                        end else begin
                            dr_q <= dr_nx;
                            for (int y = 0; y < HIT; y++)
                                data_q[y] <= relu(acc_mem[dr_nx][y]);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_repvgg_col_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_repvgg_col_engine
//  Description : Scoreboard bench for repvgg_col_engine (HIT=WID=4, CIN=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_repvgg_col_engine;

    localparam int HIT = 4;
    localparam int WID = 4;
    localparam int CIN = 2;
    localparam int DW  = 32;
    localparam int FW  = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [1:0]          mode = 2'd0;
    logic                oc_idx = 1'b0;
    logic                busy;
    logic [10*DW-1:0]    wht_i = '0;
    logic                wht_valid = 1'b0;
    logic                wht_ready;
    logic [HIT*DW-1:0]   fmap_i = '0;
    logic                fmap_valid = 1'b0;
    logic                fmap_ready;
    logic [HIT*DW-1:0]   data_o;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic                done;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    logic stall_en = 1'b0;
    logic [HIT*DW-1:0] exp_q[$];
    logic [10*DW-1:0]  wt[CIN];
    logic [HIT*DW-1:0] fm[CIN][WID];

    repvgg_col_engine #(.HIT(HIT), .WID(WID), .CIN(CIN), .DW(DW), .FW(FW), .SAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .oc_idx(oc_idx),
        .busy(busy), .wht_i(wht_i), .wht_valid(wht_valid), .wht_ready(wht_ready),
        .fmap_i(fmap_i), .fmap_valid(fmap_valid), .fmap_ready(fmap_ready),
        .data_o(data_o), .out_valid(out_valid), .out_ready(out_ready), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [HIT*DW-1:0] act, input logic [HIT*DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    function automatic logic [HIT*DW-1:0] col4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic [DW-1:0] c, input logic [DW-1:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [10*DW-1:0] wset(input logic [DW-1:0] center, input logic [DW-1:0] others,
                                              input logic [DW-1:0] w9);
        logic [10*DW-1:0] v;
        for (int k = 0; k < 9; k++) v[k*DW +: DW] = (k == 4) ? center : others;
        v[9*DW +: DW] = w9;
        return v;
    endfunction

    // Downstream accept pattern: always ready, or random when stalls are enabled.
    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops expected columns on each output transfer, checks hold-while-stalled.
    logic              stall_v = 1'b0;
    logic [HIT*DW-1:0] hold_d  = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_v = 1'b0;
        end else begin
            if (stall_v) begin
                check("hold_valid", {{(HIT*DW-1){1'b0}}, out_valid}, 1);
                check("hold_data", data_o, hold_d);
            end
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_col: got %h want none", data_o);
                end else begin
                    check("col", data_o, exp_q.pop_front());
                end
            end
            stall_v = out_valid && !out_ready;
            hold_d  = data_o;
        end
    end

    task automatic send_w(input logic [10*DW-1:0] w);
        int t = 0;
        wht_i = w; wht_valid = 1'b1;
        @(negedge clk);
        while (!wht_ready && t < 1000) begin @(negedge clk); t++; end
        if (!wht_ready) begin total++; bad++; $display("FAIL wht_timeout: got 0 want 1"); end
        @(posedge clk); #1;
        wht_valid = 1'b0;
    endtask

    task automatic send_col(input logic [HIT*DW-1:0] d, input bit gaps);
        int t = 0;
        if (gaps) begin
            fmap_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        fmap_i = d; fmap_valid = 1'b1;
        @(negedge clk);
        while (!fmap_ready && t < 1000) begin @(negedge clk); t++; end
        if (!fmap_ready) begin total++; bad++; $display("FAIL fmap_timeout: got 0 want 1"); end
        @(posedge clk); #1;
        fmap_valid = 1'b0;
    endtask

    task automatic run_job(input logic [1:0] md, input logic oc, input bit gaps);
        int t = 0;
        int d0;
        d0 = done_cnt;
        mode = md; oc_idx = oc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", {{(HIT*DW-1){1'b0}}, busy}, 1);
        for (int c = 0; c < CIN; c++) begin
            send_w(wt[c]);
            for (int x = 0; x < WID; x++) send_col(fm[c][x], gaps);
        end
        while (done_cnt == d0 && t < 1000) begin @(negedge clk); t++; end
        check("done_count", done_cnt - d0, 1);
        check("queue_empty", exp_q.size(), 0);
    endtask

    task automatic setup_t2;
        wt[0] = wset(32'h100, 32'h100, 32'h300);
        wt[1] = wset(32'h0, 32'h0, 32'h300);
        for (int c = 0; c < CIN; c++)
            for (int x = 0; x < WID; x++) fm[c][x] = col4(32'h100, 32'h100, 32'h100, 32'h100);
    endtask

    task automatic push_t2;
        exp_q.push_back(col4(32'h400, 32'h600, 32'h600, 32'h400));
        exp_q.push_back(col4(32'h600, 32'h900, 32'h900, 32'h600));
        exp_q.push_back(col4(32'h600, 32'h900, 32'h900, 32'h600));
        exp_q.push_back(col4(32'h400, 32'h600, 32'h600, 32'h400));
    endtask

    task automatic setup_t3;
        for (int c = 0; c < CIN; c++) begin
            wt[c] = wset(32'h200, 32'h0, 32'h100);
            for (int x = 0; x < WID; x++) fm[c][x] = col4(x << 8, x << 8, x << 8, x << 8);
        end
        for (int x = 0; x < WID; x++)
            exp_q.push_back(col4(6*x << 8, 6*x << 8, 6*x << 8, 6*x << 8));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ctrl", {busy, wht_ready, fmap_ready, out_valid, done}, 0);
        check("rst_data", data_o, 0);

        // Identity branch from channel oc_idx only.
        wt[0] = '0; wt[1] = '0;
        for (int x = 0; x < WID; x++) begin
            fm[0][x] = col4(32'h500, 32'h500, 32'h500, 32'h500);
            fm[1][x] = col4(32'h100, 32'h100, 32'h100, 32'h100);
            exp_q.push_back(col4(32'h100, 32'h100, 32'h100, 32'h100));
        end
        run_job(2'd0, 1'b1, 1'b0);

        // Fused 3x3 with padding; 1x1 weight ignored.
        setup_t2; push_t2;
        run_job(2'd1, 1'b0, 1'b0);

        // 3x3 + 1x1 over two channels, identity excluded.
        setup_t3;
        run_job(2'd2, 1'b0, 1'b0);

        // Negative result clamps to zero; mode 3 acts as fused mode.
        wt[0] = wset(32'hFFFF_FF00, 32'h0, 32'h300);
        wt[1] = '0;
        for (int x = 0; x < WID; x++) begin
            fm[0][x] = col4(32'h100, 32'h100, 32'h100, 32'h100);
            fm[1][x] = col4(32'h100, 32'h100, 32'h100, 32'h100);
            exp_q.push_back('0);
        end
        run_job(2'd3, 1'b0, 1'b0);

        // Saturation in the product and in the cross-channel add.
        for (int c = 0; c < CIN; c++) begin
            wt[c] = wset(32'h400, 32'h0, 32'h0);
            for (int x = 0; x < WID; x++) fm[c][x] = col4(32'h7F00_0000, 32'h7F00_0000, 32'h7F00_0000, 32'h7F00_0000);
        end
        for (int x = 0; x < WID; x++)
            exp_q.push_back(col4(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF));
        run_job(2'd1, 1'b0, 1'b0);

        // Input gaps and output back-pressure.
        setup_t2; push_t2;
        stall_en = 1'b1;
        run_job(2'd1, 1'b0, 1'b1);
        stall_en = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Abort mid-stream of channel 1.
        begin
            int d0;
            d0 = done_cnt;
            setup_t2;
            mode = 2'd1; oc_idx = 1'b0; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            send_w(wt[0]);
            for (int x = 0; x < WID; x++) send_col(fm[0][x], 1'b0);
            send_w(wt[1]);
            send_col(fm[1][0], 1'b0);
            send_col(fm[1][1], 1'b0);
            fmap_valid = 1'b1;
            rst_n = 1'b0;
            @(posedge clk); #1;
            fmap_valid = 1'b0;
            rst_n = 1'b1;
            check("abort_ctrl", {busy, wht_ready, fmap_ready, out_valid, done}, 0);
            check("abort_data", data_o, 0);
            repeat (20) @(negedge clk);
            check("abort_no_done", done_cnt - d0, 0);
            check("abort_no_out", {{(HIT*DW-1){1'b0}}, out_valid}, 0);
        end

        // Fresh job after abort.
        setup_t3;
        run_job(2'd2, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
